// File: rtl/btb_update_scheduler.sv
// Write scheduler for the 2-way BTB: buffers commit-slot updates in a small FIFO,
// drains them one per cycle, and runs the invalidate sweep after reset and on flush.
module btb_update_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int INDEX_BITS = 7
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  c0_valid,
  output logic                  c0_ready,
  input  logic [31:0]           c0_pc,
  input  logic [1:0]            c0_type,
  input  logic [31:0]           c0_bta,
  input  logic                  c1_valid,
  output logic                  c1_ready,
  input  logic [31:0]           c1_pc,
  input  logic [1:0]            c1_type,
  input  logic [31:0]           c1_bta,
  input  logic                  flush_req,
  output logic                  btb_update_en,
  output logic [31:0]           btb_update_pc,
  output logic [1:0]            btb_update_type,
  output logic [31:0]           btb_update_bta,
  output logic                  btb_clr_en,
  output logic [INDEX_BITS-1:0] btb_clr_idx,
  output logic                  busy,
  output logic                  flush_done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_M2 = CNT_W'(FIFO_DEPTH - 2);

  logic [0:0]            state;
  logic [INDEX_BITS-1:0] clr_idx;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      wr1_ptr;
  logic                  run;
  logic                  push0;
  logic                  push1;
  logic                  pop;

  logic [31:0] fifo_pc   [FIFO_DEPTH];
  logic [1:0]  fifo_type [FIFO_DEPTH];
  logic [31:0] fifo_bta  [FIFO_DEPTH];

  assign run      = (state == RUN);
  // Ready looks only at the registered count so it never depends on the drain.
  assign c0_ready = run && (count <= DEPTH_M1);
  assign c1_ready = run && (count <= DEPTH_M2);
  assign push0    = c0_valid && c0_ready;
  assign push1    = c1_valid && c1_ready;
  assign pop      = run && (count != '0);
  // Slot 1 lands behind slot 0 when both are accepted, keeping program order.
  assign wr1_ptr  = push0 ? tail + PTR_W'(1) : tail;

  assign btb_update_en   = pop;
  assign btb_update_pc   = pop ? fifo_pc[head]   : '0;
  assign btb_update_type = pop ? fifo_type[head] : '0;
  assign btb_update_bta  = pop ? fifo_bta[head]  : '0;
  assign btb_clr_en      = !run;
  assign btb_clr_idx     = clr_idx;
  assign busy            = !run;

  always_ff @(posedge clk) begin
    if (!resetn || flush_req) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (!run) begin
        if (clr_idx == '1) begin
          state      <= RUN;
          clr_idx    <= '0;
          flush_done <= 1'b1;
        end else begin
          clr_idx <= clr_idx + INDEX_BITS'(1);
        end
      end else begin
        count <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        head  <= head + PTR_W'(pop);
        tail  <= tail + PTR_W'(push0) + PTR_W'(push1);
      end
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push0) begin
      fifo_pc[tail]   <= c0_pc;
      fifo_type[tail] <= c0_type;
      fifo_bta[tail]  <= c0_bta;
    end
    if (push1) begin
      fifo_pc[wr1_ptr]   <= c1_pc;
      fifo_type[wr1_ptr] <= c1_type;
      fifo_bta[wr1_ptr]  <= c1_bta;
    end
  end
endmodule

// File: tb/tb_btb_update_scheduler.sv
// Directed bench for btb_update_scheduler with a reference queue and a small state model.
module tb_btb_update_scheduler;
  logic        clk = 1'b0;
  logic        resetn;
  logic        c0_valid, c1_valid, c0_ready, c1_ready;
  logic [31:0] c0_pc, c0_bta, c1_pc, c1_bta;
  logic [1:0]  c0_type, c1_type;
  logic        flush_req;
  logic        btb_update_en;
  logic [31:0] btb_update_pc, btb_update_bta;
  logic [1:0]  btb_update_type;
  logic        btb_clr_en;
  logic [6:0]  btb_clr_idx;
  logic        busy, flush_done;

  btb_update_scheduler #(.FIFO_DEPTH(4), .INDEX_BITS(7)) dut (
    .clk(clk), .resetn(resetn),
    .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_pc(c0_pc), .c0_type(c0_type), .c0_bta(c0_bta),
    .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_pc(c1_pc), .c1_type(c1_type), .c1_bta(c1_bta),
    .flush_req(flush_req),
    .btb_update_en(btb_update_en), .btb_update_pc(btb_update_pc),
    .btb_update_type(btb_update_type), .btb_update_bta(btb_update_bta),
    .btb_clr_en(btb_clr_en), .btb_clr_idx(btb_clr_idx), .busy(busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  ty;
    logic [31:0] bta;
  } upd_t;

  upd_t q[$];
  int   nvec = 0;
  int   nfail = 0;
  bit   m_known = 1'b0;
  bit   m_clear = 1'b1;
  int   m_idx = 0;
  bit   m_fd = 1'b0;
  int   clr_cnt = 0;
  int   fd_cnt = 0;
  int   upd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle against the model, accounts handshakes, then advances one clock.
  task automatic cyc();
    upd_t e;
    if (m_known) begin
      chk("clr_en", {31'b0, btb_clr_en}, {31'b0, m_clear});
      chk("busy", {31'b0, busy}, {31'b0, m_clear});
      if (m_clear) chk("clr_idx", {25'b0, btb_clr_idx}, m_idx);
      chk("flush_done", {31'b0, flush_done}, {31'b0, m_fd});
      chk("c0_ready", {31'b0, c0_ready}, {31'b0, !m_clear && q.size() <= 3});
      chk("c1_ready", {31'b0, c1_ready}, {31'b0, !m_clear && q.size() <= 2});
      chk("update_en", {31'b0, btb_update_en}, {31'b0, !m_clear && q.size() != 0});
      if (btb_clr_en) clr_cnt++;
      if (flush_done) fd_cnt++;
      if (!m_clear && q.size() != 0) begin
        e = q.pop_front();
        chk("upd_pc", btb_update_pc, e.pc);
        chk("upd_type", {30'b0, btb_update_type}, {30'b0, e.ty});
        chk("upd_bta", btb_update_bta, e.bta);
        upd_cnt++;
      end else begin
        chk("idle_pc", btb_update_pc, 32'h0);
      end
    end
    if (m_known && !m_clear) begin
      // readiness is judged on the pre-pop occupancy
      int occ;
      occ = q.size() + (btb_update_en ? 1 : 0);
      if (c0_valid && occ <= 3) q.push_back('{c0_pc, c0_type, c0_bta});
      if (c1_valid && occ <= 2) q.push_back('{c1_pc, c1_type, c1_bta});
    end
    if (!resetn || flush_req) begin
      if (!resetn) m_known = 1'b1;
      m_clear = 1'b1; m_idx = 0; m_fd = 1'b0; q.delete();
    end else if (m_clear) begin
      if (m_idx == 127) begin m_clear = 1'b0; m_idx = 0; m_fd = 1'b1; end
      else begin m_idx++; m_fd = 1'b0; end
    end else begin
      m_fd = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int pcv;
    resetn = 1'b0; flush_req = 1'b0;
    c0_valid = 1'b0; c0_pc = '0; c0_type = '0; c0_bta = '0;
    c1_valid = 1'b0; c1_pc = '0; c1_type = '0; c1_bta = '0;
    @(posedge clk); #1;
    idle(2);
    resetn = 1'b1;
    clr_cnt = 0; fd_cnt = 0;
    idle(132);
    chk("sweep_len", clr_cnt, 128);
    chk("sweep_fd", fd_cnt, 1);
    chk("run_c1_ready", {31'b0, c1_ready}, 32'h1);

    c0_valid = 1'b1; c0_pc = 32'h0040_1000; c0_type = 2'b01; c0_bta = 32'h0040_2000;
    cyc();
    c0_valid = 1'b0;
    chk("single_en", {31'b0, btb_update_en}, 32'h1);
    chk("single_pc", btb_update_pc, 32'h0040_1000);
    idle(1);
    chk("single_after", {31'b0, btb_update_en}, 32'h0);
    idle(2);

    c0_valid = 1'b1; c0_pc = 32'h100; c0_type = 2'b00; c0_bta = 32'h200;
    c1_valid = 1'b1; c1_pc = 32'h104; c1_type = 2'b11; c1_bta = 32'h300;
    cyc();
    c0_valid = 1'b0; c1_valid = 1'b0;
    chk("pair_first", btb_update_pc, 32'h100);
    cyc();
    chk("pair_second", btb_update_pc, 32'h104);
    idle(3);

    pcv = 32'h1000;
    for (int i = 0; i < 24; i++) begin
      c0_valid = 1'b1; c0_pc = pcv; c0_type = 2'($urandom_range(3)); c0_bta = $urandom;
      c1_valid = 1'b1; c1_pc = pcv + 4; c1_type = 2'($urandom_range(3)); c1_bta = $urandom;
      pcv += 8;
      cyc();
    end
    c0_valid = 1'b0; c1_valid = 1'b0;
    idle(6);
    chk("stream_drained", q.size(), 0);

    c0_valid = 1'b1; c0_pc = 32'h2000; c0_bta = 32'h2100;
    c1_valid = 1'b1; c1_pc = 32'h2004; c1_bta = 32'h2104;
    cyc();
    c0_pc = 32'h2008; c0_bta = 32'h2108; c1_pc = 32'h200c; c1_bta = 32'h210c;
    cyc();
    c0_valid = 1'b0; c1_valid = 1'b0;
    chk("fill3", q.size(), 3);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    upd_cnt = 0; fd_cnt = 0; clr_cnt = 0;
    idle(132);
    chk("flush_no_upd", upd_cnt, 0);
    chk("flush_sweep", clr_cnt, 128);
    chk("flush_fd", fd_cnt, 1);
    chk("flush_empty", {31'b0, btb_update_en}, 32'h0);

    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    fd_cnt = 0;
    for (int i = 0; i < 200 && !(m_clear && m_idx == 60); i++) cyc();
    chk("at_idx60", {25'b0, btb_clr_idx}, 60);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    chk("restart_flush", {25'b0, btb_clr_idx}, 0);
    for (int i = 0; i < 200 && !(m_clear && m_idx == 30); i++) cyc();
    chk("at_idx30", {25'b0, btb_clr_idx}, 30);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    chk("restart_reset", {25'b0, btb_clr_idx}, 0);
    idle(132);
    chk("one_fd", fd_cnt, 1);
    chk("end_ready", {31'b0, c0_ready}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/btb_update_scheduler.md
Name: btb_update_scheduler

Overview:
Sequences all write traffic into the 2-way, 128-set branch target buffer.
- Accepts branch-resolution updates from two in-order commit slots and buffers them in a small FIFO.
- Drains the FIFO to the BTB's single update port at one update per cycle.
- Owns the BTB invalidate sweep, which runs automatically after reset and again on each pipeline-requested flush.
- Sits between the commit stage and the BTB in the fetch unit.

Parameters:
FIFO_DEPTH, 4, number of buffered update entries (power of two, at least 2)
INDEX_BITS, 7, BTB set-index width; the sweep covers 2^INDEX_BITS sets

Ports:
clk  in  1  clock; all logic on the rising edge
resetn  in  1  reset, synchronous, active-low
c0_valid  in  1  commit slot 0 update request (older instruction)
c0_ready  out  1  slot 0 accepted when c0_valid & c0_ready
c0_pc  in  32  slot 0 branch PC
c0_type  in  2  slot 0 type: 00 direct, 01 call, 10 return, 11 indirect
c0_bta  in  32  slot 0 resolved target
c1_valid  in  1  commit slot 1 update request (younger instruction)
c1_ready  out  1  slot 1 accepted when c1_valid & c1_ready
c1_pc  in  32  slot 1 branch PC
c1_type  in  2  slot 1 type
c1_bta  in  32  slot 1 resolved target
flush_req  in  1  single-cycle pulse: discard pending updates and invalidate the BTB
btb_update_en  out  1  BTB write strobe
btb_update_pc  out  32  PC for the BTB write
btb_update_type  out  2  type for the BTB write
btb_update_bta  out  32  target for the BTB write
btb_clr_en  out  1  invalidate both ways of set btb_clr_idx
btb_clr_idx  out  INDEX_BITS  set being invalidated
busy  out  1  high while in the CLEAR state
flush_done  out  1  one-cycle pulse when a sweep completes

Behaviour:
- State machine has two states:
  - CLEAR: invalidate sweep in progress.
  - RUN: normal operation.
- Reset (resetn=0 at an edge):
  - state=CLEAR, clr_idx=0, FIFO count=0, head and tail pointers=0, flush_done=0.
  - Reset mid-sweep or mid-drain restarts the sweep at index 0 and drops all buffered entries.
- CLEAR state:
  - btb_clr_en=1, btb_clr_idx=clr_idx, busy=1.
  - c0_ready=c1_ready=0 and btb_update_en=0.
  - clr_idx increments every cycle.
  - In the cycle where clr_idx reaches 2^INDEX_BITS-1: next state=RUN, clr_idx wraps to 0, and flush_done is registered high for exactly the first RUN cycle.
  - A full sweep is 2^INDEX_BITS cycles (128 by default).
- RUN state:
  - btb_clr_en=0, busy=0.
  - c0_ready = (count <= FIFO_DEPTH-1).
  - c1_ready = (count <= FIFO_DEPTH-2).
  - Ready is computed from the registered count only; a same-cycle pop does not raise it.
  - Push order: when both slots are accepted, slot 0 is written at tail and slot 1 at tail+1, so program order is preserved.
  - If only slot 1 is accepted, it is written at tail.
  - Pointers wrap modulo FIFO_DEPTH.
  - Drain: btb_update_en = (count != 0). btb_update_pc, btb_update_type and btb_update_bta are driven combinationally from the head entry, and head pops at the edge.
  - Outputs are 0 when count=0.
  - Latency: a request accepted at edge N into an empty FIFO appears on the BTB port in cycle N+1, and that entry pops at edge N+1.
  - count_next = count + pushes − pop. Simultaneous push and pop are legal. With the ready rules above, count never exceeds FIFO_DEPTH and never underflows.
- flush_req=1 at an edge in any state:
  - Next state=CLEAR, clr_idx=0, count=0, pointers=0.
  - Requests presented in that cycle are discarded. Ready is already 0 in CLEAR; in RUN, any handshake completing that cycle is still dropped.
  - An update issued in the flush_req cycle completes normally; the sweep then clears it.
  - flush_req during CLEAR restarts the sweep at 0.
  - reset has priority over flush_req.

Test Plan:
- Release reset, hold inputs idle -> btb_clr_en=1 for exactly 128 cycles with btb_clr_idx 0..127; flush_done=1 for one cycle immediately after; busy falls with it; both readies then 1.
- In RUN, pulse c0 only with pc=0x0040_1000, type=01, bta=0x0040_2000 -> next cycle btb_update_en=1 carrying those exact values; the following cycle btb_update_en=0.
- Both slots valid for one cycle with pc 0x100 and 0x104 -> two consecutive update cycles, 0x100 then 0x104.
- Block draining by holding both slots valid every cycle -> count never exceeds 4; c1_ready drops whenever count ≥ 3 and c0_ready drops whenever count = 4; no entry is lost or reordered against a reference queue.
- Fill FIFO with 3 entries, then pulse flush_req -> no further btb_update_en; a 128-cycle sweep follows; flush_done pulses; FIFO is empty afterwards.
- Pulse flush_req at sweep index 60, then pulse resetn=0 at index 30 of the restarted sweep -> each event restarts btb_clr_idx at 0; exactly one flush_done, after the final full sweep.
